// File: rtl/util_fir_int_ctrl.sv
// Sequencer in front of util_fir_int: flushes the filter with zeros, hides start-up
// transients, gates the sample source, and changes interpolate mode only on a drained pipe.
module util_fir_int_ctrl #(
  parameter int DATA_W    = 32,
  parameter int FLUSH_LEN = 16,
  parameter int PRIME_OUT = 72,
  parameter int CNT_W     = 16,
  parameter bit HOLD_LAST = 1'b0
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              ctrl_enable,
  input  logic              ctrl_interpolate,
  input  logic              status_clr,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  output logic              fir_tvalid,
  input  logic              fir_tready,
  output logic [DATA_W-1:0] fir_tdata,
  output logic              fir_interpolate,
  input  logic              fir_m_tvalid,
  output logic              out_tvalid,
  output logic [2:0]        status_state,
  output logic [CNT_W-1:0]  status_underflow_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLUSH = 3'd1,
    S_PRIME = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  localparam int FW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam int PW = (PRIME_OUT > 1) ? $clog2(PRIME_OUT) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_LEN - 1);
  localparam logic [PW-1:0] PRIME_LAST = PW'((PRIME_OUT > 0) ? PRIME_OUT - 1 : 0);

  state_t              state_q, state_d;
  logic [FW-1:0]       fcnt_q, fcnt_d;
  logic [PW-1:0]       pcnt_q, pcnt_d;
  logic                interp_q, interp_d;
  logic [CNT_W-1:0]    ucnt_q, ucnt_d;
  logic [DATA_W-1:0]   last_q;
  logic                live, xfer, underflow;
  logic [DATA_W-1:0]   fill;

  // Source path is live in PRIME and RUN; flush and drain push zeros instead.
  assign live      = (state_q == S_PRIME) || (state_q == S_RUN);
  assign fill      = HOLD_LAST ? last_q : '0;
  assign underflow = live & fir_tready & ~s_axis_tvalid;
  assign xfer      = fir_tvalid & fir_tready;

  assign fir_tvalid           = (state_q != S_IDLE);
  assign s_axis_tready        = live & fir_tready;
  assign fir_tdata            = live ? (s_axis_tvalid ? s_axis_tdata : fill) : '0;
  assign out_tvalid           = ((state_q == S_RUN) || (state_q == S_DRAIN)) & fir_m_tvalid;
  assign fir_interpolate      = interp_q;
  assign status_state         = state_q;
  assign status_underflow_cnt = ucnt_q;

  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    pcnt_d   = pcnt_q;
    interp_d = interp_q;
    case (state_q)
      S_IDLE: begin
        interp_d = ctrl_interpolate;
        fcnt_d   = '0;
        if (ctrl_enable) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        // Pipeline holds only zeros here, so abort needs no drain.
        if (!ctrl_enable) begin
          state_d = S_IDLE;
          fcnt_d  = '0;
        end else if (xfer) begin
          if (fcnt_q == FLUSH_LAST) begin
            state_d = S_PRIME;
            fcnt_d  = '0;
            pcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q + FW'(1);
          end
        end
      end
      S_PRIME: begin
        if (!ctrl_enable) begin
          state_d = S_DRAIN;
          fcnt_d  = '0;
        end else if (PRIME_OUT == 0) begin
          state_d = S_RUN;
        end else if (fir_m_tvalid) begin
          if (pcnt_q == PRIME_LAST) state_d = S_RUN;
          else                      pcnt_d  = pcnt_q + PW'(1);
        end
      end
      S_RUN: begin
        if (!ctrl_enable || (ctrl_interpolate != interp_q)) begin
          state_d = S_DRAIN;
          fcnt_d  = '0;
        end
      end
      S_DRAIN: begin
        if (xfer) begin
          if (fcnt_q == FLUSH_LAST) begin
            // Mode is re-sampled here so requests made during the drain take effect.
            interp_d = ctrl_interpolate;
            fcnt_d   = '0;
            pcnt_d   = '0;
            state_d  = ctrl_enable ? S_PRIME : S_IDLE;
          end else begin
            fcnt_d = fcnt_q + FW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ucnt_d = ucnt_q;
    if (status_clr)                 ucnt_d = underflow ? CNT_W'(1) : '0;
    else if (underflow && ~&ucnt_q) ucnt_d = ucnt_q + CNT_W'(1);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= S_IDLE;
      fcnt_q   <= '0;
      pcnt_q   <= '0;
      interp_q <= 1'b0;
      ucnt_q   <= '0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
      pcnt_q   <= pcnt_d;
      interp_q <= interp_d;
      ucnt_q   <= ucnt_d;
      if (s_axis_tvalid && s_axis_tready) last_q <= s_axis_tdata;
    end
  end

endmodule

// File: tb/tb_util_fir_int_ctrl.sv
// Randomized bench for util_fir_int_ctrl: two instances (zero fill / 16-bit count and
// hold-last fill / 4-bit count) share one stimulus and are scored against a phase model.
module tb_util_fir_int_ctrl;
  localparam int FL = 16;
  localparam int PO = 72;

  logic        aclk = 1'b0;
  logic        areset, ctrl_enable, ctrl_interpolate, status_clr;
  logic        s_axis_tvalid, fir_tready, fir_m_tvalid;
  logic [31:0] s_axis_tdata;

  logic        s_axis_tready, fir_tvalid, fir_interpolate, out_tvalid;
  logic [31:0] fir_tdata;
  logic [2:0]  status_state;
  logic [15:0] ucnt;

  logic        b_s_axis_tready, b_fir_tvalid, b_fir_interpolate, b_out_tvalid;
  logic [31:0] b_fir_tdata;
  logic [2:0]  b_status_state;
  logic [3:0]  b_ucnt;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  util_fir_int_ctrl #(.DATA_W(32), .FLUSH_LEN(FL), .PRIME_OUT(PO), .CNT_W(16), .HOLD_LAST(1'b0)) dut (
    .aclk(aclk), .areset(areset), .ctrl_enable(ctrl_enable), .ctrl_interpolate(ctrl_interpolate),
    .status_clr(status_clr), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .fir_tvalid(fir_tvalid), .fir_tready(fir_tready),
    .fir_tdata(fir_tdata), .fir_interpolate(fir_interpolate), .fir_m_tvalid(fir_m_tvalid),
    .out_tvalid(out_tvalid), .status_state(status_state), .status_underflow_cnt(ucnt));

  util_fir_int_ctrl #(.DATA_W(32), .FLUSH_LEN(FL), .PRIME_OUT(PO), .CNT_W(4), .HOLD_LAST(1'b1)) dut4 (
    .aclk(aclk), .areset(areset), .ctrl_enable(ctrl_enable), .ctrl_interpolate(ctrl_interpolate),
    .status_clr(status_clr), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(b_s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .fir_tvalid(b_fir_tvalid), .fir_tready(fir_tready),
    .fir_tdata(b_fir_tdata), .fir_interpolate(b_fir_interpolate), .fir_m_tvalid(fir_m_tvalid),
    .out_tvalid(b_out_tvalid), .status_state(b_status_state), .status_underflow_cnt(b_ucnt));

  // Reference model: stream activity, zeros still owed, outputs still to discard.
  bit          m_act, m_drain, m_mode;
  int          m_zeros, m_disc, m_ucnt, m_ucnt4;
  logic [31:0] m_last, ramp;
  int          p_rdy, p_mv, p_sv;

  task automatic model_reset();
    m_act = 0; m_drain = 0; m_mode = 0; m_zeros = 0; m_disc = 0;
    m_ucnt = 0; m_ucnt4 = 0; m_last = '0;
  endtask

  task automatic clk_cycle(output bit run, output bit zx);
    logic [2:0]  e_state;
    logic        e_fv, e_sr, e_out;
    logic [31:0] e_data, e_data4;
    bit          xfer, uf;
    fir_tready    = (int'($urandom_range(99)) < p_rdy);
    fir_m_tvalid  = (int'($urandom_range(99)) < p_mv);
    s_axis_tvalid = (int'($urandom_range(99)) < p_sv);
    s_axis_tdata  = ramp;
    e_state = 3'd0; e_fv = 0; e_sr = 0; e_out = 0; e_data = '0; e_data4 = '0;
    if (m_act && m_zeros > 0) begin
      e_fv = 1; e_out = m_drain & fir_m_tvalid; e_state = m_drain ? 3'd4 : 3'd1;
    end else if (m_act) begin
      e_fv = 1; e_sr = fir_tready;
      e_data  = s_axis_tvalid ? ramp : 32'd0;
      e_data4 = s_axis_tvalid ? ramp : m_last;
      e_out   = (m_disc == 0) & fir_m_tvalid;
      e_state = (m_disc > 0) ? 3'd2 : 3'd3;
    end
    @(negedge aclk);
    zx = fir_tvalid & fir_tready & ~s_axis_tready;
    checks++;
    if ({status_state, fir_tvalid, s_axis_tready, out_tvalid, fir_interpolate, fir_tdata} !==
        {e_state, e_fv, e_sr, e_out, m_mode, e_data}) begin
      errors++;
      $display("FAIL cycle_outputs t=%0t got st=%0d fv=%b sr=%b out=%b mode=%b d=%h exp st=%0d fv=%b sr=%b out=%b mode=%b d=%h",
               $time, status_state, fir_tvalid, s_axis_tready, out_tvalid, fir_interpolate, fir_tdata,
               e_state, e_fv, e_sr, e_out, m_mode, e_data);
    end
    checks++;
    if ({b_status_state, b_fir_interpolate, b_fir_tdata} !== {e_state, m_mode, e_data4}) begin
      errors++;
      $display("FAIL hold_last_outputs t=%0t got st=%0d d=%h exp st=%0d d=%h",
               $time, b_status_state, b_fir_tdata, e_state, e_data4);
    end
    checks++;
    if (ucnt !== 16'(m_ucnt) || b_ucnt !== 4'(m_ucnt4)) begin
      errors++;
      $display("FAIL underflow_cnt t=%0t got %0d/%0d exp %0d/%0d", $time, ucnt, b_ucnt, m_ucnt, m_ucnt4);
    end
    xfer = e_fv & fir_tready;
    uf   = m_act && m_zeros == 0 && fir_tready && !s_axis_tvalid;
    if (e_sr && s_axis_tvalid) begin m_last = ramp; ramp = ramp + 1; end
    if (status_clr) begin m_ucnt = uf ? 1 : 0; m_ucnt4 = uf ? 1 : 0; end
    else if (uf) begin
      if (m_ucnt < 65535) m_ucnt++;
      if (m_ucnt4 < 15) m_ucnt4++;
    end
    if (!m_act) begin
      m_mode = ctrl_interpolate;
      if (ctrl_enable) begin m_act = 1; m_zeros = FL; m_drain = 0; end
    end else if (m_zeros > 0 && !m_drain) begin
      if (!ctrl_enable) begin m_act = 0; m_zeros = 0; end
      else if (xfer) begin m_zeros--; if (m_zeros == 0) m_disc = PO; end
    end else if (m_zeros > 0) begin
      if (xfer) begin
        m_zeros--;
        if (m_zeros == 0) begin
          m_mode = ctrl_interpolate; m_drain = 0;
          if (ctrl_enable) m_disc = PO; else m_act = 0;
        end
      end
    end else if (m_disc > 0) begin
      if (!ctrl_enable) begin m_zeros = FL; m_drain = 1; end
      else if (fir_m_tvalid) m_disc--;
    end else if (!ctrl_enable || ctrl_interpolate != m_mode) begin
      m_zeros = FL; m_drain = 1;
    end
    @(posedge aclk); #1;
    run = m_act && m_zeros == 0 && m_disc == 0;
  endtask

  task automatic test_reset();
    areset = 1; ctrl_enable = 0; ctrl_interpolate = 0; status_clr = 0;
    s_axis_tvalid = 0; fir_tready = 0; fir_m_tvalid = 0; s_axis_tdata = '0;
    repeat (2) @(posedge aclk);
    #1;
    checks++;
    if ({status_state, fir_tvalid, s_axis_tready, out_tvalid, fir_interpolate, fir_tdata, ucnt, b_ucnt} !== '0) begin
      errors++;
      $display("FAIL reset_state got st=%0d fv=%b cnt=%0d exp all zero", status_state, fir_tvalid, ucnt);
    end
    areset = 0; model_reset(); ramp = 32'h0001_0001;
  endtask

  task automatic test_prime();
    bit run, zx; int nz = 0; int n = 0;
    ctrl_enable = 1; ctrl_interpolate = 1; p_sv = 100; p_rdy = 80; p_mv = 50;
    run = 0;
    while (!run && n < 3000) begin clk_cycle(run, zx); nz += int'(zx); n++; end
    checks++;
    if (!run || nz != FL) begin
      errors++;
      $display("FAIL prime_sequence reached_run=%b zero_xfers=%0d exp 1/%0d", run, nz, FL);
    end
    repeat (20) clk_cycle(run, zx);
  endtask

  task automatic test_underflow();
    bit run, zx;
    p_rdy = 100; p_sv = 0;
    repeat (3) clk_cycle(run, zx);
    p_sv = 100;
    clk_cycle(run, zx);
    checks++;
    if (ucnt !== 16'd3 || b_ucnt !== 4'd3) begin
      errors++;
      $display("FAIL underflow_three got %0d/%0d exp 3/3", ucnt, b_ucnt);
    end
    p_rdy = 70; p_sv = 70;
    repeat (100) clk_cycle(run, zx);
  endtask

  task automatic test_mode_switch();
    bit run, zx; int nz = 0; int n = 0;
    p_rdy = 75; p_sv = 80; p_mv = 60;
    ctrl_interpolate = 0;
    clk_cycle(run, zx);
    while (!run && n < 3000) begin clk_cycle(run, zx); nz += int'(zx); n++; end
    checks++;
    if (!run || nz != FL || fir_interpolate !== 1'b0) begin
      errors++;
      $display("FAIL mode_switch reached_run=%b zero_xfers=%0d mode=%b exp 1/%0d/0", run, nz, fir_interpolate, FL);
    end
    repeat (30) clk_cycle(run, zx);
  endtask

  task automatic test_enable_drop();
    bit run, zx; int nz = 0; int n = 0;
    ctrl_enable = 0;
    while (m_act && n < 500) begin clk_cycle(run, zx); nz += int'(zx); n++; end
    checks++;
    if (status_state !== 3'd0 || nz != FL) begin
      errors++;
      $display("FAIL drain_to_idle got st=%0d zero_xfers=%0d exp 0/%0d", status_state, nz, FL);
    end
    ctrl_enable = 1;
    repeat (3) clk_cycle(run, zx);
    ctrl_enable = 0;
    clk_cycle(run, zx);
    checks++;
    if (status_state !== 3'd0 || fir_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL flush_abort got st=%0d fv=%b exp 0/0", status_state, fir_tvalid);
    end
  endtask

  task automatic test_saturate();
    bit run, zx; int n = 0;
    ctrl_enable = 1; p_sv = 100; p_rdy = 80;
    run = 0;
    while (!run && n < 3000) begin clk_cycle(run, zx); n++; end
    p_sv = 0; p_rdy = 100;
    repeat (20) clk_cycle(run, zx);
    checks++;
    if (b_ucnt !== 4'd15) begin
      errors++;
      $display("FAIL cnt_saturate got %0d exp 15", b_ucnt);
    end
    status_clr = 1;
    clk_cycle(run, zx);
    status_clr = 0; p_sv = 100;
    checks++;
    if (b_ucnt !== 4'd1 || ucnt !== 16'd1) begin
      errors++;
      $display("FAIL clr_with_inc got %0d/%0d exp 1/1", ucnt, b_ucnt);
    end
    repeat (5) clk_cycle(run, zx);
  endtask

  task automatic test_areset();
    areset = 1;
    #2;
    checks++;
    if ({status_state, fir_tvalid, s_axis_tready, out_tvalid, fir_interpolate, fir_tdata, ucnt, b_ucnt} !== '0) begin
      errors++;
      $display("FAIL async_reset got st=%0d fv=%b sr=%b cnt=%0d exp all zero", status_state, fir_tvalid, s_axis_tready, ucnt);
    end
    @(posedge aclk); #1;
    areset = 0; model_reset();
    test_prime();
  endtask

  initial begin
    p_rdy = 0; p_mv = 0; p_sv = 0;
    test_reset();
    test_prime();
    test_underflow();
    test_mode_switch();
    test_enable_drop();
    test_saturate();
    test_areset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
